shr_stage_sequencer: RTL and testbench
======================================

# shr_stage_sequencer

Drives the read/write stage schedule consumed by the shift-register control blocks: it emits `rd_stage` stepping 0..NUM_STAGES-1 for a programmed number of passes, plus `wr_stage`, which is the same schedule delayed by a fixed lag. It is the producer side of the `rd_stage`/`wr_stage` interface; SHRin/SHRout control logic decodes these stages into mux, mode and address selects. A start/busy/done handshake sits toward the layer controller, and an optional stall freezes the schedule.

## Interface
- `NUM_STAGES`, default 11: stages per pass; `rd_stage` runs 0..NUM_STAGES-1.
- `STAGE_W`, default 4: width of the stage buses; must satisfy 2^STAGE_W >= NUM_STAGES.
- `WR_LAG`, default 1: unstalled-cycle delay from `rd_stage` to `wr_stage`; minimum 1.
- `PASS_W`, default 8: width of the pass count.
- `clk`, input, 1: clock; all logic is on the rising edge.
- `rst`, input, 1: reset, asynchronous assert, active-low.
- `start`, input, 1: begin a job; sampled only in IDLE.
- `n_pass`, input, PASS_W: number of passes, latched with `start`.
- `stall`, input, 1: freeze the schedule.
- `rd_stage`, output, STAGE_W: current read stage.
- `rd_valid`, output, 1: `rd_stage` is live this cycle.
- `wr_stage`, output, STAGE_W: current write stage.
- `wr_valid`, output, 1: `wr_stage` is live this cycle.
- `busy`, output, 1: a job is in progress.
- `done`, output, 1: one-cycle completion pulse.
- `abort`, input, 1: present only with `SHR_SEQ_ABORT_EN`.

## Operation
- **Reset values** (asynchronous, while `rst` is 0): state IDLE, `rd_stage`=0, `wr_stage`=0, `rd_valid`=0, `wr_valid`=0, `busy`=0, `done`=0, pass counter 0, delay line cleared.
- **Reset mid-job:** the job is discarded and no `done` is produced.
- **FSM states:** IDLE, RUN, DRAIN, DONE.
- **IDLE:**
  - `start`=1 with `n_pass`!=0: latch `n_pass`, clear the pass counter, go to RUN with `rd_stage`=0.
  - `start` with `n_pass`=0 is ignored; the FSM stays in IDLE and no `done` is produced.
- **RUN:**
  - On an unstalled cycle, `rd_valid`=1.
  - `rd_stage` increments each unstalled cycle.
  - At NUM_STAGES-1, `rd_stage` wraps to 0 and the pass counter increments.
  - On the last stage of the last pass, go to DRAIN; `rd_stage` returns to 0.
- **DRAIN:**
  - `rd_valid`=0.
  - Lasts WR_LAG unstalled cycles, so the delay line empties.
  - Then go to DONE.
- **DONE:**
  - `done`=1 for exactly one cycle, then return to IDLE.
  - DONE ignores `stall`.
- **Delay line:**
  - `wr_stage`/`wr_valid` are `rd_stage`/`rd_valid` delayed WR_LAG unstalled cycles.
  - The delay line shifts only when `stall`=0.
- **Stall (`stall`=1, in RUN or DRAIN):**
  - Holds `rd_stage`, `wr_stage`, the pass counter, the drain counter and the delay line.
  - Forces `rd_valid`=0 and `wr_valid`=0 for that cycle.
  - Stages resume unchanged on the next unstalled cycle.
- **`start` while busy:** ignored; the latched `n_pass` does not change.
- **Arithmetic:** the pass counter is PASS_W bits and compared against the latched `n_pass`; it never wraps, since its maximum is n_pass-1. `rd_stage` compares against NUM_STAGES-1 and never reaches NUM_STAGES.

## Timing
- `start` sampled at edge E: the first `rd_valid`=1 cycle, with `rd_stage`=0, follows E.
- Without stall, `rd_valid` is high for exactly n_pass*NUM_STAGES consecutive cycles.
- The first `wr_valid` comes WR_LAG cycles after the first `rd_valid`.
- The last `wr_valid` comes WR_LAG cycles after the last `rd_valid`.
- `done` is high in the cycle after the last `wr_valid`.
- `busy` is high from the first RUN cycle through the `done` cycle inclusive.
- Unstalled job length, start edge to `done`: n_pass*NUM_STAGES + WR_LAG + 1 cycles.
- Each stalled cycle adds one cycle to the job.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- **`SHR_SEQ_ABORT_EN` defined:**
  - Adds the `abort` input.
  - `abort`=1 in RUN or DRAIN: next cycle is IDLE, `rd_valid`/`wr_valid`/`busy` low, delay line cleared, no `done`.
  - `abort` has priority over `stall`.
  - `abort` in IDLE or DONE is ignored; a DONE pulse still completes.
- **Undefined:** no `abort` port, no abort logic.

## Structure
- **Shared package:**
  - FSM state enum: IDLE, RUN, DRAIN, DONE.
  - Default NUM_STAGES (11), WR_LAG (1), STAGE_W (4).
- **Sub-module `shr_stage_delay`:**
  - Parameterized WR_LAG-deep shift line of {valid, stage}.
  - Has an enable, driven by !stall, and a synchronous clear, used by abort.
  - Resets to all zero.

## Test plan
- **Reset:** `rst`=0 mid-RUN at `rd_stage`=6 -> all outputs 0 immediately; after release, IDLE and no `done`.
- **Single pass:** `n_pass`=1, defaults -> `rd_stage` 0..10 on 11 consecutive cycles; `wr_stage` is the same one cycle later; `done` at start+13; `busy` high 13 cycles.
- **Three passes:** `n_pass`=3 -> 33 `rd_valid` cycles with `rd_stage` wrapping 10->0 twice; exactly one `done`, at start+35.
- **Stall:** `stall`=1 for 2 cycles while `rd_stage`=5 -> `rd_valid` and `wr_valid` low for 2 cycles; `rd_stage` resumes at 6; `done` delayed by 2 cycles.
- **Ignored starts:** `n_pass`=0 -> no `busy`, no `done`; `start` pulsed during RUN with `n_pass`=7 -> original count kept.
- **Abort (`SHR_SEQ_ABORT_EN`):** `abort` at `rd_stage`=8 of pass 1 -> IDLE next cycle, no `done`, `wr_valid` 0; a following job runs normally.

Source files
------------

// File: rtl/shr_stage_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shr_stage_sequencer_pkg
// Description : Shared types and default parameters for the SHR stage
//               sequencer: FSM state encoding, default stage count, write
//               lag and bus widths, plus a small state-decode helper.
// Config      : SHR_SEQ_ABORT_EN (used by the interface and the top only)
// Revision    : 1.0 - initial release
// ============================================================================
package shr_stage_sequencer_pkg;

  localparam int unsigned c_NUM_STAGES_DEFAULT = 11;
  localparam int unsigned c_WR_LAG_DEFAULT     = 1;
  localparam int unsigned c_STAGE_W_DEFAULT    = 4;
  localparam int unsigned c_PASS_W_DEFAULT     = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

  // States in which the schedule is live and stall/abort take effect.
  function automatic logic is_active(input seq_state_e st);
    return (st == ST_RUN) || (st == ST_DRAIN);
  endfunction

endpackage
`default_nettype wire

// File: rtl/shr_stage_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : shr_stage_sequencer_if
// Description : Handshake and stage bus between the stage sequencer and its
//               surroundings (layer controller and SHRin/SHRout control).
//   master : the sequencer  - drives rd_stage/rd_valid, wr_stage/wr_valid,
//                             busy, done; receives start, n_pass, stall
//   slave  : the environment - the opposite directions
// Config      : SHR_SEQ_ABORT_EN adds the abort request line.
// Revision    : 1.0 - initial release
// ============================================================================
interface shr_stage_sequencer_if
  import shr_stage_sequencer_pkg::*;
#(
  parameter int STAGE_W = c_STAGE_W_DEFAULT,
  parameter int PASS_W  = c_PASS_W_DEFAULT
);

  logic                start;
  logic [PASS_W-1:0]   n_pass;
  logic                stall;
`ifdef SHR_SEQ_ABORT_EN
  logic                abort;
`endif
  logic [STAGE_W-1:0]  rd_stage;
  logic                rd_valid;
  logic [STAGE_W-1:0]  wr_stage;
  logic                wr_valid;
  logic                busy;
  logic                done;

  modport master (
`ifdef SHR_SEQ_ABORT_EN
    input  abort,
`endif
    input  start, n_pass, stall,
    output rd_stage, rd_valid, wr_stage, wr_valid, busy, done
  );

  modport slave (
`ifdef SHR_SEQ_ABORT_EN
    output abort,
`endif
    output start, n_pass, stall,
    input  rd_stage, rd_valid, wr_stage, wr_valid, busy, done
  );

endinterface
`default_nettype wire

// File: rtl/shr_stage_delay.sv
`default_nettype none
// ============================================================================
// Module      : shr_stage_delay
// Description : WR_LAG-deep shift line of {valid, stage}. Shifts only when
//               en is high; clr empties the line synchronously.
//   clk, rst    : clock, asynchronous active-low reset (line cleared)
//   en          : shift enable
//   clr         : synchronous clear, wins over en
//   in_valid/in_stage   : value entering the line
//   out_valid/out_stage : value leaving the line (WR_LAG shifts later)
// Revision    : 1.0 - initial release
// ============================================================================
module shr_stage_delay #(
  parameter int STAGE_W = 4,
  parameter int WR_LAG  = 1
) (
  input  wire logic               clk,
  input  wire logic               rst,
  input  wire logic               en,
  input  wire logic               clr,
  input  wire logic               in_valid,
  input  wire logic [STAGE_W-1:0] in_stage,
  output logic                    out_valid,
  output logic [STAGE_W-1:0]      out_stage
);

  localparam int c_W = STAGE_W + 1;

  logic [WR_LAG-1:0][c_W-1:0] r_line;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_line <= '0;
    end else if (clr) begin
      r_line <= '0;
    end else if (en) begin
      r_line[0] <= {in_valid, in_stage};
      for (int i = 1; i < WR_LAG; i++) begin
        r_line[i] <= r_line[i-1];
      end
    end
  end

  assign {out_valid, out_stage} = r_line[WR_LAG-1];

endmodule
`default_nettype wire

// File: rtl/shr_stage_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : shr_stage_sequencer
// Description : Produces the read/write stage schedule for the shift-register
//               control blocks. rd_stage steps 0..NUM_STAGES-1 for n_pass
//               passes; wr_stage is the same schedule WR_LAG unstalled cycles
//               later. start/busy/done handshake toward the layer controller;
//               stall freezes the schedule.
//   clk  : clock, rising edge
//   rst  : asynchronous reset, active-low
//   bus  : shr_stage_sequencer_if.master (start, n_pass, stall, [abort] in;
//          rd_stage, rd_valid, wr_stage, wr_valid, busy, done out)
// Config      : SHR_SEQ_ABORT_EN - when defined, abort in RUN/DRAIN returns
//               to IDLE next cycle without a done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module shr_stage_sequencer
  import shr_stage_sequencer_pkg::*;
#(
  parameter int NUM_STAGES = c_NUM_STAGES_DEFAULT,
  parameter int STAGE_W    = c_STAGE_W_DEFAULT,
  parameter int WR_LAG     = c_WR_LAG_DEFAULT,
  parameter int PASS_W     = c_PASS_W_DEFAULT
) (
  input  wire logic               clk,
  input  wire logic               rst,
  shr_stage_sequencer_if.master   bus
);

  localparam logic [STAGE_W-1:0] c_LAST_STAGE = STAGE_W'(NUM_STAGES - 1);
  localparam int                 c_DRAIN_W    = (WR_LAG > 1) ? $clog2(WR_LAG) : 1;
  localparam logic [c_DRAIN_W-1:0] c_DRAIN_LAST = c_DRAIN_W'(WR_LAG - 1);

  seq_state_e            r_state;
  logic [STAGE_W-1:0]    r_rd_stage;
  logic                  r_sch_valid;  // schedule slot holds a real stage
  logic                  r_stalled;    // previous edge was a stalled one
  logic                  r_busy;
  logic                  r_done;
  logic [PASS_W-1:0]     r_pass;
  logic [PASS_W-1:0]     r_n_pass;
  logic [c_DRAIN_W-1:0]  r_drain;

  logic                  w_active;
  logic                  w_abort;
  logic                  w_shift;
  logic                  w_last_item;
  logic                  w_wr_valid;
  logic [STAGE_W-1:0]    w_wr_stage;

  assign w_active = is_active(r_state);

`ifdef SHR_SEQ_ABORT_EN
  assign w_abort = bus.abort & w_active;
`else
  assign w_abort = 1'b0;
`endif

  // Stall only freezes the schedule while it is live; DONE/IDLE ignore it.
  assign w_shift = ~(w_active & bus.stall);

  assign w_last_item = (r_rd_stage == c_LAST_STAGE) &&
                       (r_pass == (r_n_pass - PASS_W'(1)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_rd_stage  <= '0;
      r_sch_valid <= 1'b0;
      r_stalled   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= '0;
      r_n_pass    <= '0;
      r_drain     <= '0;
    end else begin
      r_done    <= 1'b0;
      r_stalled <= 1'b0;
      if (w_abort) begin
        r_state     <= ST_IDLE;
        r_rd_stage  <= '0;
        r_sch_valid <= 1'b0;
        r_busy      <= 1'b0;
        r_pass      <= '0;
        r_drain     <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (bus.start && (bus.n_pass != '0)) begin
              r_n_pass    <= bus.n_pass;
              r_pass      <= '0;
              r_rd_stage  <= '0;
              r_sch_valid <= 1'b1;
              r_busy      <= 1'b1;
              r_state     <= ST_RUN;
            end
          end
          ST_RUN: begin
            if (bus.stall) begin
              r_stalled <= 1'b1;
            end else if (w_last_item) begin
              r_state     <= ST_DRAIN;
              r_rd_stage  <= '0;
              r_sch_valid <= 1'b0;
              r_drain     <= '0;
            end else if (r_rd_stage == c_LAST_STAGE) begin
              r_rd_stage <= '0;
              r_pass     <= r_pass + PASS_W'(1);
            end else begin
              r_rd_stage <= r_rd_stage + STAGE_W'(1);
            end
          end
          ST_DRAIN: begin
            if (bus.stall) begin
              r_stalled <= 1'b1;
            end else if (r_drain == c_DRAIN_LAST) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_drain <= r_drain + c_DRAIN_W'(1);
            end
          end
          ST_DONE: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // The line carries the schedule, not the gated outputs, so a stall does
  // not insert a bubble into the write side.
  shr_stage_delay #(
    .STAGE_W (STAGE_W),
    .WR_LAG  (WR_LAG)
  ) u_delay (
    .clk       (clk),
    .rst       (rst),
    .en        (w_shift),
    .clr       (w_abort),
    .in_valid  (r_sch_valid),
    .in_stage  (r_rd_stage),
    .out_valid (w_wr_valid),
    .out_stage (w_wr_stage)
  );

  // Valids are masked for the cycle following a stalled edge; both terms are
  // flops, so no input reaches an output combinationally.
  assign bus.rd_stage = r_rd_stage;
  assign bus.rd_valid = r_sch_valid & ~r_stalled;
  assign bus.wr_stage = w_wr_stage;
  assign bus.wr_valid = w_wr_valid & ~r_stalled;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_shr_stage_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_shr_stage_sequencer
// Description : Directed self-checking bench for shr_stage_sequencer with
//               default parameters (11 stages, write lag 1).
// Config      : SHR_SEQ_ABORT_EN enables the abort steps.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shr_stage_sequencer;

  localparam int NS  = 11;
  localparam int LAG = 1;

  logic clk = 1'b0;
  logic rst = 1'b0;

  shr_stage_sequencer_if #(.STAGE_W(4), .PASS_W(8)) sif ();

  shr_stage_sequencer #(
    .NUM_STAGES (NS),
    .STAGE_W    (4),
    .WR_LAG     (LAG),
    .PASS_W     (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input int cyc,
                     input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp)
    else begin
      n_mis++;
      $error("FAIL %s @%0d: observed %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input int np);
    sif.n_pass = 8'(np);
    sif.start  = 1'b1;
    step();
    sif.start  = 1'b0;
  endtask

  // Expected outputs k cycles after the start edge of an unstalled job with
  // n items (n_pass*NS).
  task automatic chk_cycle(input int k, input int n);
    logic ev_rd, ev_wr;
    ev_rd = (k >= 1) && (k <= n);
    ev_wr = (k >= 1 + LAG) && (k <= n + LAG);
    chk("rd_valid", k, 32'(sif.rd_valid), 32'(ev_rd));
    if (ev_rd) chk("rd_stage", k, 32'(sif.rd_stage), 32'((k - 1) % NS));
    else       chk("rd_stage_idle", k, 32'(sif.rd_stage), 32'd0);
    chk("wr_valid", k, 32'(sif.wr_valid), 32'(ev_wr));
    if (ev_wr) chk("wr_stage", k, 32'(sif.wr_stage), 32'((k - 1 - LAG) % NS));
    chk("done", k, 32'(sif.done), 32'(k == n + LAG + 1));
    chk("busy", k, 32'(sif.busy), 32'((k >= 1) && (k <= n + LAG + 1)));
  endtask

  task automatic chk_idle(input string tag, input int cyc);
    chk({tag, "_busy"},     cyc, 32'(sif.busy),     32'd0);
    chk({tag, "_done"},     cyc, 32'(sif.done),     32'd0);
    chk({tag, "_rd_valid"}, cyc, 32'(sif.rd_valid), 32'd0);
    chk({tag, "_wr_valid"}, cyc, 32'(sif.wr_valid), 32'd0);
  endtask

  initial begin
    sif.start  = 1'b0;
    sif.n_pass = '0;
    sif.stall  = 1'b0;
`ifdef SHR_SEQ_ABORT_EN
    sif.abort  = 1'b0;
`endif

    // Reset state
    step();
    step();
    chk_idle("reset", 0);
    chk("reset_rd_stage", 0, 32'(sif.rd_stage), 32'd0);
    chk("reset_wr_stage", 0, 32'(sif.wr_stage), 32'd0);
    rst = 1'b1;
    step();
    chk_idle("post_reset", 0);

    // Single pass
    start_job(1);
    for (int k = 1; k <= NS + LAG + 3; k++) begin
      chk_cycle(k, NS);
      step();
    end

    // Three passes; a start with n_pass=7 during RUN must be ignored
    start_job(3);
    for (int k = 1; k <= 3 * NS + LAG + 3; k++) begin
      chk_cycle(k, 3 * NS);
      if (k == 5) begin
        sif.n_pass = 8'd7;
        sif.start  = 1'b1;
      end else begin
        sif.start  = 1'b0;
      end
      step();
    end

    // start with n_pass=0 is ignored
    sif.n_pass = 8'd0;
    sif.start  = 1'b1;
    step();
    sif.start  = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      chk_idle("npass0", k);
      step();
    end

    // Two stalled edges while rd_stage=5
    start_job(1);
    for (int k = 1; k <= 6; k++) begin
      chk_cycle(k, NS);
      if (k < 6) step();
    end
    sif.stall = 1'b1;
    step();
    chk("stall_rd_valid", 7, 32'(sif.rd_valid), 32'd0);
    chk("stall_rd_stage", 7, 32'(sif.rd_stage), 32'd5);
    chk("stall_wr_valid", 7, 32'(sif.wr_valid), 32'd0);
    chk("stall_wr_stage", 7, 32'(sif.wr_stage), 32'd4);
    chk("stall_busy",     7, 32'(sif.busy),     32'd1);
    step();
    sif.stall = 1'b0;
    chk("stall_rd_valid", 8, 32'(sif.rd_valid), 32'd0);
    chk("stall_rd_stage", 8, 32'(sif.rd_stage), 32'd5);
    chk("stall_wr_valid", 8, 32'(sif.wr_valid), 32'd0);
    chk("stall_done",     8, 32'(sif.done),     32'd0);
    step();
    // From here the job is the unstalled one shifted by two cycles.
    for (int k = 7; k <= NS + LAG + 3; k++) begin
      chk_cycle(k, NS);
      step();
    end

    // Reset asserted mid-RUN at rd_stage=6
    start_job(2);
    for (int k = 1; k <= 7; k++) begin
      chk_cycle(k, 2 * NS);
      if (k < 7) step();
    end
    rst = 1'b0;
    #1;
    chk_idle("midreset", 7);
    chk("midreset_rd_stage", 7, 32'(sif.rd_stage), 32'd0);
    chk("midreset_wr_stage", 7, 32'(sif.wr_stage), 32'd0);
    step();
    step();
    rst = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk_idle("after_midreset", k);
    end

`ifdef SHR_SEQ_ABORT_EN
    // Abort at rd_stage=8 of the second pass
    start_job(2);
    for (int k = 1; k <= 20; k++) begin
      chk_cycle(k, 2 * NS);
      if (k < 20) step();
    end
    sif.abort = 1'b1;
    step();
    sif.abort = 1'b0;
    chk_idle("abort", 21);
    chk("abort_rd_stage", 21, 32'(sif.rd_stage), 32'd0);
    for (int k = 22; k <= 25; k++) begin
      step();
      chk_idle("after_abort", k);
    end
    step();
    start_job(1);
    for (int k = 1; k <= NS + LAG + 3; k++) begin
      chk_cycle(k, NS);
      step();
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
